vam_job_arbiter: RTL and testbench

- Shares one VAM-16 multiplier between NREQ requesters.
- Round-robin selects a requester, latches its packed operand word and drives it onto the multiplier's 32-bit operand bus (opndA in [31:16], opndB in [15:0]).
- Pulses the multiplier start, waits for its ready pulse, then returns the 32-bit result tagged with the requester ID.
- Guards against a hung multiplier with a timeout and a recovery window.

---
 rtl/vam_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/vam_job_arbiter.sv | 143 ++++++++++++++
 tb/tb_vam_job_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vam_ctrl_pkg.sv
// rtl/vam_ctrl_pkg.sv - shared widths, FSM states and operand packing for the VAM job arbiter
package vam_ctrl_pkg;

  localparam int OPND_W = 16;
  localparam int BUS_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    RESP,
    RECOVER
  } state_t;

  function automatic logic [BUS_W-1:0] pack_opnds(input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b);
    return {a, b};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick; first set request at or above rr_ptr, wrapping
module rr_arbiter #(
  parameter int  NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (enable && !any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/vam_job_arbiter.sv
// rtl/vam_job_arbiter.sv - shares one VAM-16 multiplier between NREQ requesters with timeout recovery
module vam_job_arbiter
  import vam_ctrl_pkg::*;
#(
  parameter int  NREQ        = 4,
  parameter int  TIMEOUT_CYC = 64,
  parameter int  RECOVER_CYC = 16,
  localparam int ID_W        = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*32-1:0]  req_opnd,
  output logic [NREQ-1:0]     req_ready,
  output logic [BUS_W-1:0]    mul_bus32,
  output logic                mul_start,
  input  logic [BUS_W-1:0]    mul_rslt,
  input  logic                mul_ready,
  output logic                resp_valid,
  output logic [ID_W-1:0]     resp_id,
  output logic [BUS_W-1:0]    resp_data,
  output logic                resp_err,
  output logic                busy
);

  localparam int TMAX  = (TIMEOUT_CYC > RECOVER_CYC) ? TIMEOUT_CYC : RECOVER_CYC;
  localparam int TMR_W = $clog2(TMAX + 1);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [BUS_W-1:0] bus_q, bus_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [BUS_W-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic             arb_en;
  logic [NREQ-1:0]  arb_grant;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic [BUS_W-1:0] sel_word;

  // Gated by rst so no grant leaks out while the block is held in reset.
  assign arb_en = (state_q == IDLE) && rst;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign sel_word = req_opnd[arb_idx*BUS_W +: BUS_W];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    bus_d       = bus_q;
    id_d        = id_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          bus_d    = pack_opnds(sel_word[BUS_W-1:OPND_W], sel_word[OPND_W-1:0]);
          id_d     = arb_idx;
          rr_ptr_d = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
          state_d  = SETUP;
        end
      end
      SETUP: state_d = START;
      START: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A ready on the expiry cycle still counts as a good result.
        if (mul_ready) begin
          resp_id_d   = id_q;
          resp_data_d = mul_rslt;
          resp_err_d  = 1'b0;
          state_d     = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          resp_id_d   = id_q;
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          state_d     = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP: begin
        timer_d = '0;
        state_d = resp_err_q ? RECOVER : IDLE;
      end
      RECOVER: begin
        if (timer_q == TMR_W'(RECOVER_CYC - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      bus_q       <= '0;
      id_q        <= '0;
      resp_id_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      bus_q       <= bus_d;
      id_q        <= id_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready  = arb_grant;
  assign mul_bus32  = bus_q;
  assign mul_start  = (state_q == START);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vam_job_arbiter.sv
// tb/tb_vam_job_arbiter.sv - scoreboard bench with a latency-configurable multiplier model
module tb_vam_job_arbiter;

  localparam int NREQ        = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int RECOVER_CYC = 16;
  localparam int ID_W        = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_opnd;
  logic [NREQ-1:0]     req_ready;
  logic [31:0]         mul_bus32;
  logic                mul_start;
  logic [31:0]         mul_rslt;
  logic                mul_ready;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_data;
  logic                resp_err;
  logic                busy;

  vam_job_arbiter #(
    .NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT_CYC), .RECOVER_CYC(RECOVER_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_opnd(req_opnd), .req_ready(req_ready),
    .mul_bus32(mul_bus32), .mul_start(mul_start), .mul_rslt(mul_rslt), .mul_ready(mul_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  // multiplier model knobs: ready arrives mul_lat+1 cycles after the start cycle
  int mul_lat    = 5;
  bit no_ready   = 1'b0;
  bit spur_start = 1'b0;

  // reference model state
  int              ref_ptr    = 0;
  int              busy_until = -1;
  int              last_grant = -1;
  bit              start_due  = 1'b0;
  logic [31:0]     granted_word = '0;
  logic [31:0]     prev_bus   = '0;
  logic [ID_W-1:0] last_id    = '0;
  logic [31:0]     last_data  = '0;
  logic            last_err   = 1'b0;
  int              grant_cnt  = 0;
  int              mon_g;
  int              mon_idx;
  bit              exp_busy;
  logic [NREQ-1:0] exp_ready;
  logic [31:0]     w, a32, b32;
  exp_t            e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // multiplier model: returns A*B of the bus word present at start
  initial begin : mul_model
    logic [31:0] ma, mb;
    mul_ready = 1'b0;
    mul_rslt  = '0;
    forever begin
      @(negedge clk);
      if (rst && mul_start) begin
        ma = {16'h0, mul_bus32[31:16]};
        mb = {16'h0, mul_bus32[15:0]};
        if (spur_start) begin
          mul_ready = 1'b1;
          mul_rslt  = 32'hDEAD_BEEF;
        end
        @(posedge clk); #1;
        mul_ready = 1'b0;
        mul_rslt  = $urandom;
        if (!no_ready) begin
          if (mul_lat > 0) begin
            repeat (mul_lat) @(posedge clk);
            #1;
          end
          mul_ready = 1'b1;
          mul_rslt  = ma * mb;
          @(posedge clk); #1;
          mul_ready = 1'b0;
          mul_rslt  = $urandom;
        end
      end
    end
  end

  // monitor: predicts grants, busy and response timing; pops and compares responses
  initial begin : monitor
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (!rst) begin
        check("reset_ctl", {req_ready, mul_start, resp_valid, resp_id, resp_err, busy}, '0);
        check("reset_data", {mul_bus32, resp_data}, '0);
        sb.delete();
        ref_ptr = 0; busy_until = -1; last_grant = -1; start_due = 1'b0;
        last_id = '0; last_data = '0; last_err = 1'b0; prev_bus = '0;
      end else begin
        exp_busy = (cyc > last_grant) && (cyc <= busy_until);
        check("busy", busy, exp_busy);
        mon_g = -1;
        if (!exp_busy) begin
          for (int k = 0; k < NREQ; k++) begin
            mon_idx = (ref_ptr + k) % NREQ;
            if (mon_g < 0 && req_valid[mon_idx]) mon_g = mon_idx;
          end
        end
        exp_ready = '0;
        if (mon_g >= 0) exp_ready[mon_g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        if (mon_g >= 0) begin
          w     = req_opnd[32*mon_g +: 32];
          a32   = {16'h0, w[31:16]};
          b32   = {16'h0, w[15:0]};
          e.id  = mon_g;
          e.err = no_ready || (mul_lat + 1 > TIMEOUT_CYC);
          e.data = e.err ? 32'h0 : a32 * b32;
          e.at  = e.err ? cyc + 3 + TIMEOUT_CYC : cyc + 4 + mul_lat;
          sb.push_back(e);
          busy_until   = e.at + (e.err ? RECOVER_CYC : 0);
          last_grant   = cyc;
          ref_ptr      = (mon_g + 1) % NREQ;
          granted_word = w;
          start_due    = 1'b1;
          grant_cnt++;
        end
        if (mul_start) begin
          check("start_pending", start_due, 1'b1);
          check("start_cycle", cyc, last_grant + 2);
          check("bus_before_start", prev_bus, granted_word);
          start_due = 1'b0;
        end
        if (resp_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_resp_valid", resp_valid, 1'b0);
          end else begin
            e = sb.pop_front();
            check("resp_id", resp_id, e.id);
            check("resp_data", resp_data, e.data);
            check("resp_err", resp_err, e.err);
            check("resp_cycle", cyc, e.at);
            last_id = resp_id; last_data = resp_data; last_err = resp_err;
          end
        end else begin
          check("resp_hold", {resp_id, resp_data, resp_err}, {last_id, last_data, last_err});
        end
        prev_bus = mul_bus32;
      end
    end
  end

  task automatic wait_grant(input int id);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (req_ready[id] === 1'b1) break;
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL grant_timeout: req%0d not granted after %0d cycles, required a grant", id, n);
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    @(posedge clk);
    while ((busy || sb.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL drain_timeout: busy=%0d pending=%0d after %0d cycles, required idle", busy, sb.size(), n);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_job(input int id, input logic [31:0] word);
    @(posedge clk); #1;
    req_opnd[32*id +: 32] = word;
    req_valid = NREQ'(1) << id;
    wait_grant(id);
    @(posedge clk); #1;
    req_valid = '0;
    wait_quiet(300);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int lats[4];
    int base, n;
    lats = '{0, 1, 3, 7};
    rst = 1'b1;
    req_valid = '1;
    req_opnd = {$urandom, $urandom, $urandom, $urandom};
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    req_valid = '0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);

    run_job(0, 32'h00F0_0186);
    run_job(3, $urandom);

    base = grant_cnt;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) req_opnd[32*i +: 32] = 32'h0002_0003 * (i + 1);
    req_valid = '1;
    n = 0;
    while (grant_cnt < base + 5 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++; failures++;
      $display("FAIL rr_burst_timeout: %0d grants seen, required 5", grant_cnt - base);
    end
    #1 req_valid = '0;
    wait_quiet(400);

    mul_lat = 69;
    run_job(1, $urandom);
    mul_lat = 5;
    run_job(2, 32'h8960_0006);

    mul_lat = 63;
    run_job(0, $urandom);
    mul_lat = 64;
    run_job(3, $urandom);

    mul_lat = 5;
    spur_start = 1'b1;
    run_job(1, $urandom);
    spur_start = 1'b0;

    foreach (lats[li]) begin
      mul_lat = lats[li];
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        for (int r = 0; r < NREQ; r++) req_opnd[32*r +: 32] = $urandom;
      end
      @(posedge clk); #1;
      req_valid = '0;
      wait_quiet(400);
    end

    mul_lat = 5;
    no_ready = 1'b1;
    @(posedge clk); #1;
    req_opnd[63:32] = $urandom;
    req_valid = 4'b0010;
    wait_grant(1);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    no_ready = 1'b0;
    req_opnd[31:0]  = $urandom;
    req_opnd[95:64] = 32'h0016_8960;
    req_valid = 4'b0101;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    wait_grant(2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_quiet(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
